// File: rtl/pursuit_ram_loader.sv
// pursuit_ram_loader
//
// Fills one of the pursuit processor's on-chip RAMs from an external byte
// stream, or zero-fills it without consuming input. Bytes are assembled into
// words (order set by BIG_ENDIAN) and written to consecutive addresses
// starting at 0 in the selected target RAM.
//
// Ports:
//   i_clock          single clock, rising edge
//   i_reset          synchronous active-high reset
//   i_start          job request, sampled only while idle
//   i_channel        target RAM index, sampled with i_start
//   i_mode           0: stream load, 1: zero fill; sampled with i_start
//   i_word_count     number of words to write, sampled with i_start
//   i_byte_valid     input byte present
//   i_byte_data      input byte
//   o_byte_ready     loader accepts a byte (transfer when valid & ready)
//   o_ram_write_en   one-hot write strobe, one bit per target RAM
//   o_ram_write_addr write address
//   o_ram_write_data write data
//   o_busy           job in progress
//   o_done           one-cycle job-complete pulse
//   o_error          qualifies o_done: job was rejected
module pursuit_ram_loader #(
  parameter int WORD_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 12,
  parameter int NUM_CHANNELS = 3,
  parameter bit BIG_ENDIAN   = 1'b1
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic                            i_start,
  input  logic [$clog2(NUM_CHANNELS)-1:0] i_channel,
  input  logic                            i_mode,
  input  logic [ADDR_WIDTH:0]             i_word_count,
  input  logic                            i_byte_valid,
  input  logic [7:0]                      i_byte_data,
  output logic                            o_byte_ready,
  output logic [NUM_CHANNELS-1:0]         o_ram_write_en,
  output logic [ADDR_WIDTH-1:0]           o_ram_write_addr,
  output logic [WORD_WIDTH-1:0]           o_ram_write_data,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_error
);

  localparam int BPW  = WORD_WIDTH / 8;
  localparam int CH_W = $clog2(NUM_CHANNELS);
  localparam int BC_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BC_W-1:0]     LAST_BYTE = BC_W'(BPW - 1);
  localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_WORD  = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_ZERO, S_DONE} state_t;

  state_t                  r_state,      w_state_next;
  logic [CH_W-1:0]         r_chan,       w_chan_next;
  logic [ADDR_WIDTH-1:0]   r_last,       w_last_next;      // address of final word
  logic [ADDR_WIDTH-1:0]   r_addr,       w_addr_next;      // next address to write
  logic [ADDR_WIDTH-1:0]   r_fill_idx,   w_fill_idx_next;  // word being assembled
  logic [BC_W-1:0]         r_byte_cnt,   w_byte_cnt_next;
  logic [WORD_WIDTH-1:0]   r_asm,        w_asm_next;
  logic                    r_pending,    w_pending_next;   // assembled word awaits write
  logic                    r_reject,     w_reject_next;
  logic                    r_byte_ready, w_byte_ready_next;
  logic [NUM_CHANNELS-1:0] r_wr_en,      w_wr_en_next;
  logic [ADDR_WIDTH-1:0]   r_wr_addr,    w_wr_addr_next;
  logic [WORD_WIDTH-1:0]   r_wr_data,    w_wr_data_next;
  logic                    r_busy,       w_busy_next;
  logic                    r_done,       w_done_next;
  logic                    r_error,      w_error_next;

  logic                    w_accept;
  logic                    w_bad_req;
  logic [WORD_WIDTH-1:0]   w_asm_shift;
  logic [NUM_CHANNELS-1:0] w_chan_onehot;

  assign w_accept  = r_byte_ready & i_byte_valid;
  assign w_bad_req = ({1'b0, i_channel} >= (CH_W + 1)'(NUM_CHANNELS)) ||
                     (i_word_count > MAX_WORDS);

  // Byte insertion: big-endian shifts toward the MSB so the first byte ends
  // up on top; little-endian shifts toward the LSB so it ends up at [7:0].
  generate
    if (BIG_ENDIAN) begin : g_big
      assign w_asm_shift = (r_asm << 8) | WORD_WIDTH'(i_byte_data);
    end else begin : g_little
      assign w_asm_shift = (r_asm >> 8) | (WORD_WIDTH'(i_byte_data) << (WORD_WIDTH - 8));
    end
  endgenerate

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_onehot
    assign w_chan_onehot[gi] = (r_chan == CH_W'(gi));
  end

  always_comb begin
    w_state_next      = r_state;
    w_chan_next       = r_chan;
    w_last_next       = r_last;
    w_addr_next       = r_addr;
    w_fill_idx_next   = r_fill_idx;
    w_byte_cnt_next   = r_byte_cnt;
    w_asm_next        = r_asm;
    w_pending_next    = r_pending;
    w_reject_next     = r_reject;
    w_byte_ready_next = r_byte_ready;
    w_wr_en_next      = '0;
    w_wr_addr_next    = r_wr_addr;
    w_wr_data_next    = r_wr_data;
    w_busy_next       = r_busy;
    w_done_next       = 1'b0;
    w_error_next      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_chan_next     = i_channel;
          w_last_next     = ADDR_WIDTH'(i_word_count - ONE_WORD);
          w_addr_next     = '0;
          w_fill_idx_next = '0;
          w_byte_cnt_next = '0;
          w_pending_next  = 1'b0;
          w_reject_next   = w_bad_req;
          if (w_bad_req || (i_word_count == '0)) begin
            w_state_next = S_DONE;
          end else if (i_mode) begin
            w_state_next = S_ZERO;
            w_busy_next  = 1'b1;
          end else begin
            w_state_next      = S_FILL;
            w_busy_next       = 1'b1;
            w_byte_ready_next = 1'b1;
          end
        end
      end

      S_FILL: begin
        // Write the word completed on the previous edge; runs in parallel
        // with assembly of the next word.
        if (r_pending) begin
          w_pending_next = 1'b0;
          w_wr_en_next   = w_chan_onehot;
          w_wr_addr_next = r_addr;
          w_wr_data_next = r_asm;
          if (r_addr == r_last) begin
            w_state_next = S_DONE;
          end else begin
            w_addr_next = r_addr + ADDR_WIDTH'(1);
          end
        end
        if (w_accept) begin
          w_asm_next = w_asm_shift;
          if (r_byte_cnt == LAST_BYTE) begin
            w_byte_cnt_next = '0;
            w_pending_next  = 1'b1;
            // Stop taking bytes as soon as the final word is complete.
            if (r_fill_idx == r_last) begin
              w_byte_ready_next = 1'b0;
            end else begin
              w_fill_idx_next = r_fill_idx + ADDR_WIDTH'(1);
            end
          end else begin
            w_byte_cnt_next = r_byte_cnt + BC_W'(1);
          end
        end
      end

      S_ZERO: begin
        w_wr_en_next   = w_chan_onehot;
        w_wr_addr_next = r_addr;
        w_wr_data_next = '0;
        if (r_addr == r_last) begin
          w_state_next = S_DONE;
        end else begin
          w_addr_next = r_addr + ADDR_WIDTH'(1);
        end
      end

      S_DONE: begin
        w_done_next       = 1'b1;
        w_error_next      = r_reject;
        w_busy_next       = 1'b0;
        w_byte_ready_next = 1'b0;
        w_state_next      = S_IDLE;
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_chan       <= '0;
      r_last       <= '0;
      r_addr       <= '0;
      r_fill_idx   <= '0;
      r_byte_cnt   <= '0;
      r_asm        <= '0;
      r_pending    <= 1'b0;
      r_reject     <= 1'b0;
      r_byte_ready <= 1'b0;
      r_wr_en      <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_chan       <= w_chan_next;
      r_last       <= w_last_next;
      r_addr       <= w_addr_next;
      r_fill_idx   <= w_fill_idx_next;
      r_byte_cnt   <= w_byte_cnt_next;
      r_asm        <= w_asm_next;
      r_pending    <= w_pending_next;
      r_reject     <= w_reject_next;
      r_byte_ready <= w_byte_ready_next;
      r_wr_en      <= w_wr_en_next;
      r_wr_addr    <= w_wr_addr_next;
      r_wr_data    <= w_wr_data_next;
      r_busy       <= w_busy_next;
      r_done       <= w_done_next;
      r_error      <= w_error_next;
    end
  end

  assign o_byte_ready     = r_byte_ready;
  assign o_ram_write_en   = r_wr_en;
  assign o_ram_write_addr = r_wr_addr;
  assign o_ram_write_data = r_wr_data;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_error          = r_error;

endmodule

// File: tb/tb_pursuit_ram_loader.sv
// Bench for pursuit_ram_loader: a big-endian instance (a_*) carries most jobs,
// a little-endian instance (b_*) checks byte order under backpressure.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge, where cycle number N means "value registered by rising edge N".
module tb_pursuit_ram_loader;

  localparam int WW  = 32;
  localparam int AW  = 12;
  localparam int NCH = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic           a_start, a_mode, a_valid, a_ready, a_busy, a_done, a_error;
  logic [1:0]     a_channel;
  logic [AW:0]    a_wc;
  logic [7:0]     a_data;
  logic [NCH-1:0] a_en;
  logic [AW-1:0]  a_addr;
  logic [WW-1:0]  a_wdata;

  logic           b_start, b_mode, b_valid, b_ready, b_busy, b_done, b_error;
  logic [1:0]     b_channel;
  logic [AW:0]    b_wc;
  logic [7:0]     b_data;
  logic [NCH-1:0] b_en;
  logic [AW-1:0]  b_addr;
  logic [WW-1:0]  b_wdata;

  pursuit_ram_loader #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .NUM_CHANNELS(NCH), .BIG_ENDIAN(1'b1)) u_dut_a (
    .i_clock(clk), .i_reset(rst), .i_start(a_start), .i_channel(a_channel), .i_mode(a_mode),
    .i_word_count(a_wc), .i_byte_valid(a_valid), .i_byte_data(a_data), .o_byte_ready(a_ready),
    .o_ram_write_en(a_en), .o_ram_write_addr(a_addr), .o_ram_write_data(a_wdata),
    .o_busy(a_busy), .o_done(a_done), .o_error(a_error));

  pursuit_ram_loader #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .NUM_CHANNELS(NCH), .BIG_ENDIAN(1'b0)) u_dut_b (
    .i_clock(clk), .i_reset(rst), .i_start(b_start), .i_channel(b_channel), .i_mode(b_mode),
    .i_word_count(b_wc), .i_byte_valid(b_valid), .i_byte_data(b_data), .o_byte_ready(b_ready),
    .o_ram_write_en(b_en), .o_ram_write_addr(b_addr), .o_ram_write_data(b_wdata),
    .o_busy(b_busy), .o_done(b_done), .o_error(b_error));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             cyc;
    logic [NCH-1:0] en;
    logic [AW-1:0]  addr;
    logic [WW-1:0]  data;
  } wr_t;

  // Monitors: sole writers of the capture state; jobs use snapshots.
  wr_t  a_wq[$];
  int   a_done_cnt = 0, a_done_cyc = 0, a_ready_cnt = 0, a_busy_cnt = 0;
  logic a_done_err = 1'b0;
  always @(negedge clk) begin
    if (|a_en) a_wq.push_back('{cyc, a_en, a_addr, a_wdata});
    if (a_done) begin
      a_done_cnt++;
      a_done_cyc = cyc;
      a_done_err = a_error;
    end
    if (a_ready) a_ready_cnt++;
    if (a_busy)  a_busy_cnt++;
  end

  int             b_wr_cnt = 0, b_last_cyc = 0, b_done_cnt = 0, b_done_cyc = 0;
  logic [NCH-1:0] b_last_en = '0;
  logic [AW-1:0]  b_last_addr = '0;
  logic [WW-1:0]  b_last_data = '0;
  logic           b_done_err = 1'b0;
  always @(negedge clk) begin
    if (|b_en) begin
      b_wr_cnt++;
      b_last_cyc  = cyc;
      b_last_en   = b_en;
      b_last_addr = b_addr;
      b_last_data = b_wdata;
    end
    if (b_done) begin
      b_done_cnt++;
      b_done_cyc = cyc;
      b_done_err = b_error;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_write(input string tag, input int idx, input int exp_cyc,
                             input logic [NCH-1:0] exp_en, input int exp_addr, input logic [WW-1:0] exp_data);
    if (idx >= a_wq.size()) begin
      check_val({tag, "_present"}, 64'(a_wq.size()), 64'(idx + 1));
    end else begin
      check_val({tag, "_cyc"},  64'(a_wq[idx].cyc), 64'(exp_cyc));
      check_val({tag, "_en"},   64'(a_wq[idx].en),  64'(exp_en));
      check_val({tag, "_addr"}, 64'(a_wq[idx].addr), 64'(exp_addr));
      check_val({tag, "_data"}, 64'(a_wq[idx].data), 64'(exp_data));
    end
  endtask

  // Start pulse on the falling edge; returns positioned on the falling edge
  // of cycle e0 (the edge that sampled start).
  task automatic a_launch(input logic [1:0] ch, input logic m, input logic [AW:0] wc, output int e0);
    @(negedge clk);
    a_start = 1'b1; a_channel = ch; a_mode = m; a_wc = wc;
    e0 = cyc + 1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  // Offer n bytes (MSB-first packed) back-to-back; each transfers on the
  // rising edge following a falling edge where ready is seen high.
  task automatic a_send(input logic [63:0] bytes, input int n);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 100) begin
      a_valid = 1'b1;
      a_data  = bytes[8*(n-1-k) +: 8];
      if (a_ready) k++;
      guard++;
      @(negedge clk);
    end
    a_valid = 1'b0;
    if (k < n) check_val("send_timeout", 64'(k), 64'(n));
  endtask

  task automatic a_wait_done(input int base_cnt, input int limit);
    int g = 0;
    while (a_done_cnt == base_cnt && g < limit) begin
      @(negedge clk);
      g++;
    end
    if (a_done_cnt == base_cnt) check_val("done_timeout", 64'(0), 64'(1));
  endtask

  typedef struct {
    string       name;
    logic [1:0]  ch;
    logic [AW:0] wc;
    logic        exp_err;
  } rej_t;

  initial begin
    int   e0, bw, bd, rc, bc;
    rej_t rej[4];

    rst = 1'b1;
    a_start = 1'b0; a_channel = '0; a_mode = 1'b0; a_wc = '0; a_valid = 1'b0; a_data = '0;
    b_start = 1'b0; b_channel = '0; b_mode = 1'b0; b_wc = '0; b_valid = 1'b0; b_data = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check_val("rst_ready", 64'(a_ready), 64'(0));
    check_val("rst_en",    64'(a_en),    64'(0));
    check_val("rst_addr",  64'(a_addr),  64'(0));
    check_val("rst_data",  64'(a_wdata), 64'(0));
    check_val("rst_busy",  64'(a_busy),  64'(0));
    check_val("rst_done",  64'(a_done),  64'(0));
    check_val("rst_error", 64'(a_error), 64'(0));
    check_val("rst_b_en",  64'(b_en),    64'(0));
    $display("job reset: outputs idle");
    rst = 1'b0;

    // Big-endian 2-word load: bytes transfer at e0+1..e0+8, writes at
    // e0+5 and e0+9, done at e0+10.
    bw = a_wq.size(); bd = a_done_cnt;
    a_launch(2'd0, 1'b0, 13'd2, e0);
    check_val("be_busy_e0",  64'(a_busy),  64'(1));
    check_val("be_ready_e0", 64'(a_ready), 64'(1));
    a_send(64'h3F80_0000_4000_0000, 8);
    check_val("be_ready_after_last", 64'(a_ready), 64'(0));
    a_wait_done(bd, 50);
    repeat (3) @(negedge clk);
    check_val("be_nwrites", 64'(a_wq.size() - bw), 64'(2));
    check_write("be_w0", bw,     e0 + 5, 3'b001, 0, 32'h3F80_0000);
    check_write("be_w1", bw + 1, e0 + 9, 3'b001, 1, 32'h4000_0000);
    check_val("be_done_cyc", 64'(a_done_cyc), 64'(e0 + 10));
    check_val("be_error",    64'(a_done_err), 64'(0));
    check_val("be_pulses",   64'(a_done_cnt - bd), 64'(1));
    check_val("be_busy_end", 64'(a_busy), 64'(0));
    $display("job big-endian load: %0d writes, done at e0+%0d", a_wq.size() - bw, a_done_cyc - e0);

    // Little-endian, byte_valid every other cycle: transfers at e0+1,3,5,7,
    // write at e0+8, done at e0+9.
    bd = b_done_cnt; bc = b_wr_cnt;
    @(negedge clk);
    b_start = 1'b1; b_channel = 2'd1; b_mode = 1'b0; b_wc = 13'd1;
    e0 = cyc + 1;
    @(negedge clk);
    b_start = 1'b0;
    begin
      logic [31:0] v = 32'h0102_0304;
      int k = 0;
      int i = 0;
      while (k < 4 && i < 40) begin
        b_valid = ((i % 2) == 0);
        b_data  = v[8*(3-k) +: 8];
        if (b_valid && b_ready) k++;
        i++;
        @(negedge clk);
      end
      b_valid = 1'b0;
      if (k < 4) check_val("le_send_timeout", 64'(k), 64'(4));
    end
    repeat (4) @(negedge clk);
    check_val("le_nwrites",  64'(b_wr_cnt - bc), 64'(1));
    check_val("le_data",     64'(b_last_data), 64'h0403_0201);
    check_val("le_addr",     64'(b_last_addr), 64'(0));
    check_val("le_en",       64'(b_last_en),   64'(3'b010));
    check_val("le_wr_cyc",   64'(b_last_cyc),  64'(e0 + 8));
    check_val("le_done_cyc", 64'(b_done_cyc),  64'(e0 + 9));
    check_val("le_pulses",   64'(b_done_cnt - bd), 64'(1));
    check_val("le_error",    64'(b_done_err),  64'(0));
    $display("job little-endian load: data 0x%08h", b_last_data);

    // Zero fill at full depth with a byte offered throughout (must be ignored).
    bw = a_wq.size(); bd = a_done_cnt; rc = a_ready_cnt;
    a_valid = 1'b1; a_data = 8'hAA;
    a_launch(2'd2, 1'b1, 13'd4096, e0);
    a_wait_done(bd, 5000);
    a_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("zf_nwrites", 64'(a_wq.size() - bw), 64'(4096));
    for (int i = 0; i < 4096; i++) check_write("zf", bw + i, e0 + 1 + i, 3'b100, i, '0);
    check_val("zf_done_cyc", 64'(a_done_cyc), 64'(e0 + 4097));
    check_val("zf_error",    64'(a_done_err), 64'(0));
    check_val("zf_ready",    64'(a_ready_cnt - rc), 64'(0));
    $display("job zero fill: %0d writes, done at e0+%0d", a_wq.size() - bw, a_done_cyc - e0);

    // Rejected and zero-length jobs: done at e0+1, no writes, never busy.
    rej[0] = '{"rej_ch3",     2'd3, 13'd1,    1'b1};
    rej[1] = '{"rej_wc4097",  2'd0, 13'd4097, 1'b1};
    rej[2] = '{"rej_ch3_wc0", 2'd3, 13'd0,    1'b1};
    rej[3] = '{"zero_len",    2'd0, 13'd0,    1'b0};
    for (int r = 0; r < 4; r++) begin
      bw = a_wq.size(); bd = a_done_cnt; bc = a_busy_cnt;
      a_launch(rej[r].ch, 1'b0, rej[r].wc, e0);
      a_wait_done(bd, 10);
      repeat (3) @(negedge clk);
      check_val({rej[r].name, "_nwrites"},  64'(a_wq.size() - bw), 64'(0));
      check_val({rej[r].name, "_done_cyc"}, 64'(a_done_cyc), 64'(e0 + 1));
      check_val({rej[r].name, "_error"},    64'(a_done_err), 64'(rej[r].exp_err));
      check_val({rej[r].name, "_busy"},     64'(a_busy_cnt - bc), 64'(0));
      check_val({rej[r].name, "_pulses"},   64'(a_done_cnt - bd), 64'(1));
      $display("job %s: error=%0d", rej[r].name, a_done_err);
    end

    // start pulsed mid-FILL is ignored: one write at e0+6, done e0+7, and no
    // zero-fill job follows.
    bw = a_wq.size(); bd = a_done_cnt;
    a_launch(2'd1, 1'b0, 13'd1, e0);
    a_send(64'h1122, 2);
    a_start = 1'b1; a_channel = 2'd0; a_mode = 1'b1; a_wc = 13'd5;
    @(negedge clk);
    a_start = 1'b0;
    a_send(64'h3344, 2);
    a_wait_done(bd, 50);
    repeat (10) @(negedge clk);
    check_val("ms_nwrites", 64'(a_wq.size() - bw), 64'(1));
    check_write("ms_w0", bw, e0 + 6, 3'b010, 0, 32'h1122_3344);
    check_val("ms_done_cyc", 64'(a_done_cyc), 64'(e0 + 7));
    check_val("ms_pulses",   64'(a_done_cnt - bd), 64'(1));
    $display("job mid-job start: %0d writes", a_wq.size() - bw);

    // Reset after 5 bytes of a 2-word load. Word 0 (bytes 1-4) is complete
    // and written at e0+5; byte 5 is a partial word and must be discarded.
    bw = a_wq.size(); bd = a_done_cnt;
    a_launch(2'd0, 1'b0, 13'd2, e0);
    a_send(64'h01_0203_0405, 5);
    rst = 1'b1;
    @(negedge clk);
    check_val("mr_ready", 64'(a_ready), 64'(0));
    check_val("mr_en",    64'(a_en),    64'(0));
    check_val("mr_addr",  64'(a_addr),  64'(0));
    check_val("mr_data",  64'(a_wdata), 64'(0));
    check_val("mr_busy",  64'(a_busy),  64'(0));
    check_val("mr_done",  64'(a_done),  64'(0));
    check_val("mr_error", 64'(a_error), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_val("mr_nwrites", 64'(a_wq.size() - bw), 64'(1));
    check_write("mr_w0", bw, e0 + 5, 3'b001, 0, 32'h0102_0304);
    check_val("mr_pulses", 64'(a_done_cnt - bd), 64'(0));
    bw = a_wq.size(); bd = a_done_cnt;
    a_launch(2'd2, 1'b0, 13'd1, e0);
    a_send(64'hDEAD_BEEF, 4);
    a_wait_done(bd, 50);
    repeat (3) @(negedge clk);
    check_val("pr_nwrites", 64'(a_wq.size() - bw), 64'(1));
    check_write("pr_w0", bw, e0 + 5, 3'b100, 0, 32'hDEAD_BEEF);
    check_val("pr_error", 64'(a_done_err), 64'(0));
    $display("job reset mid-load then reload: %0d writes after reset", a_wq.size() - bw);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
